// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//
// UART serial transmitter. Takes one parallel word over a valid/ready
// handshake and sends it on a serial line:
//   start bit (0), DATA_BITS data bits LSB first, an optional parity bit,
//   then STOP_BITS stop bits (1).
// Every change on tx lines up with a baud_tick, so each bit lasts exactly one
// baud period. The design sits between the host/FIFO side and the tx pad.
//
// Parameters
//   DATA_BITS   data bits per frame, 5..9
//   PARITY_EN   1 = add a parity bit after the data bits
//   PARITY_ODD  1 = odd parity, 0 = even (ignored when PARITY_EN = 0)
//   STOP_BITS   stop bits per frame, 1..2
//
// Ports
//   clk        in   system clock (the same clock that drives the baud generator)
//   rst_n      in   asynchronous reset, active low
//   baud_tick  in   one-cycle strobe per bit period
//   tx_data    in   word to send; latched when a word is accepted
//   tx_valid   in   tx_data is valid
//   tx_ready   out  the block can accept a word in this cycle
//   tx         out  serial line, idle high, registered
//   tx_busy    out  a frame is in progress (any state other than IDLE)
//   tx_done    out  one-cycle pulse when the last stop bit ends
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int             CNT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic           ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   sr_q, sr_d;
  logic                   parity_q, parity_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  // Set when the next word was accepted during the last stop bit but the
  // tick that ends that bit has not arrived yet.
  logic                   pending_q, pending_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;

  logic                   last_stop;
  logic                   accept;

  // The next word can be taken in IDLE, or during the final stop bit so the
  // following frame starts right at the end of this one. After a word is
  // taken early (pending), ready drops so the held word is not overwritten.
  assign last_stop = (state_q == ST_STOP) && (stop_cnt_q == LAST_STOP);
  assign tx_ready  = (state_q == ST_IDLE) || (last_stop && !pending_q);
  assign accept    = tx_valid && tx_ready;
  assign tx_busy   = (state_q != ST_IDLE);
  assign tx        = tx_q;
  assign tx_done   = done_q;

  // NOTE: every signal written here gets a default first; any path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    parity_d   = parity_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    pending_d  = pending_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    // Latch the word and its parity at accept. The parity is computed once
    // here, so the shift register can be consumed freely later.
    if (accept) begin
      sr_d     = tx_data;
      parity_d = (^tx_data) ^ ODD;
    end

    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        // A tick in the same cycle is not used: SYNC waits for the next one,
        // so the start bit always lasts a full period.
        if (accept) begin
          state_d = ST_SYNC;
        end
      end

      ST_SYNC: begin
        if (baud_tick) begin
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end

      ST_START: begin
        if (baud_tick) begin
          state_d   = ST_DATA;
          tx_d      = sr_q[0];
          bit_cnt_d = '0;
        end
      end

      ST_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d    = ST_STOP;
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            // sr_q[0] is the bit on the line now; the next one is sr_q[1].
            sr_d      = sr_q >> 1;
            tx_d      = sr_q[1];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_PARITY: begin
        if (baud_tick) begin
          state_d    = ST_STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end

      ST_STOP: begin
        if (accept) begin
          pending_d = 1'b1;
        end
        if (baud_tick) begin
          if (last_stop) begin
            done_d     = 1'b1;
            stop_cnt_d = 1'b0;
            if (accept || pending_q) begin
              // Back-to-back: the start bit begins on this same tick, with
              // no idle gap, and SYNC is skipped.
              state_d   = ST_START;
              tx_d      = 1'b0;
              pending_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all
  // registers update together from the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      pending_q  <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      parity_q   <= parity_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      pending_q  <= pending_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//
// Self-checking bench for uart_tx. It drives four instances:
//   0: 8N1          1: 8E1 (even parity)   2: 8O1 (odd parity)   3: 7N2
// baud_tick comes once every 16 clocks from a free-running cycle counter.
// Stimulus pushes each hand-written expected frame (the bit string in line
// order) into a per-instance queue. A monitor for each instance watches the
// serial line, pops the frame when a start bit appears, and checks each
// clock of the frame, the mid-bit samples, the tx_done pulse, and optional
// start latency and zero-gap back-to-back timing.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  localparam int TICK = 16;

  typedef struct {
    logic [15:0] bits;     // bit i = i-th bit sent on the line
    int          nbits;
    bit          b2b;      // must start on the same cycle the previous done shows
    bit          chk_lat;  // start cycle must equal exp_start[k]
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  logic       baud_tick;

  logic [8:0] data_v  [4];
  logic [3:0] valid_v = 4'b0;
  wire  [3:0] ready_line, tx_line, busy_line, done_line;

  frame_t     exp_q [4][$];
  int         exp_start [4];
  int         last_done [4];
  bit         mon_on = 1'b0;

  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign baud_tick = (cyc % TICK == TICK - 1);

  uart_tx #(.DATA_BITS(8)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .tx_data(data_v[0][7:0]), .tx_valid(valid_v[0]), .tx_ready(ready_line[0]),
    .tx(tx_line[0]), .tx_busy(busy_line[0]), .tx_done(done_line[0]));

  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .tx_data(data_v[1][7:0]), .tx_valid(valid_v[1]), .tx_ready(ready_line[1]),
    .tx(tx_line[1]), .tx_busy(busy_line[1]), .tx_done(done_line[1]));

  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .tx_data(data_v[2][7:0]), .tx_valid(valid_v[2]), .tx_ready(ready_line[2]),
    .tx(tx_line[2]), .tx_busy(busy_line[2]), .tx_done(done_line[2]));

  uart_tx #(.DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .tx_data(data_v[3][6:0]), .tx_valid(valid_v[3]), .tx_ready(ready_line[3]),
    .tx(tx_line[3]), .tx_busy(busy_line[3]), .tx_done(done_line[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int k, input string s, input bit b2b, input bit lat);
    frame_t f;
    f.bits    = '0;
    f.nbits   = s.len();
    f.b2b     = b2b;
    f.chk_lat = lat;
    for (int i = 0; i < s.len(); i++) f.bits[i] = (s[i] == 8'h31);
    exp_q[k].push_back(f);
  endtask

  // Offer a word and wait (bounded) for ready; the word is taken on the
  // rising edge right after the negedge where ready is seen. With align set,
  // the word is offered only in a cycle where baud_tick is high.
  task automatic send(input int k, input logic [8:0] d, input bit align);
    int i;
    @(negedge clk);
    for (i = 0; i < 1000; i++) begin
      if (ready_line[k] && (!align || (cyc % TICK == TICK - 1))) break;
      @(negedge clk);
    end
    data_v[k]  = d;
    valid_v[k] = 1'b1;
    check("ready_seen", ready_line[k], 1'b1);
    exp_start[k] = cyc + TICK + 1;
    @(negedge clk);
    valid_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k);
    for (int i = 0; i < 2000; i++) begin
      if (done_line[k]) break;
      @(negedge clk);
    end
    check("done_seen", done_line[k], 1'b1);
    @(negedge clk);
  endtask

  // Called at the negedge where tx first shows 0. Returns at the negedge where
  // tx_done should be high, so a back-to-back start at that negedge is seen.
  task automatic run_frame(input int k);
    frame_t      f;
    logic [15:0] rx;
    int          bad, bad_done;
    if (exp_q[k].size() == 0) begin
      check("unexpected_start", tx_line[k], 1'b1);
      for (int i = 0; i < 400 && tx_line[k] !== 1'b1; i++) @(negedge clk);
      return;
    end
    f = exp_q[k].pop_front();
    if (f.chk_lat) check("start_latency", cyc, exp_start[k]);
    if (f.b2b) check("b2b_gap", cyc, last_done[k]);
    rx = '0;
    bad = 0;
    bad_done = 0;
    for (int n = 0; n < TICK * f.nbits; n++) begin
      if (n > 0) @(negedge clk);
      if (tx_line[k] !== f.bits[n / TICK]) bad++;
      if (n > 0 && done_line[k] !== 1'b0) bad_done++;
      if (n % TICK == TICK / 2) rx[n / TICK] = tx_line[k];
    end
    @(negedge clk);
    check("frame_bits", rx, f.bits);
    check("bit_width_errs", bad, 0);
    check("done_in_frame", bad_done, 0);
    check("done_at_end", done_line[k], 1'b1);
    last_done[k] = cyc;
  endtask

  task automatic monitor(input int k);
    @(negedge clk);
    forever begin
      if (mon_on && tx_line[k] === 1'b0) run_frame(k);
      else @(negedge clk);
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);
  initial monitor(3);

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  dones, drops;
    bit  acc2;
    for (int k = 0; k < 4; k++) begin
      data_v[k]    = '0;
      last_done[k] = -1;
      exp_start[k] = 0;
    end

    // Reset state of all four instances.
    repeat (3) @(negedge clk);
    check("rst_tx", tx_line, 4'hF);
    check("rst_ready", ready_line, 4'hF);
    check("rst_busy", busy_line, 4'h0);
    check("rst_done", done_line, 4'h0);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of the data bits (monitors off).
    send(0, 9'h000, 1'b0);
    repeat (58) @(negedge clk);
    check("pre_rst_tx", tx_line[0], 1'b0);
    check("pre_rst_busy", busy_line[0], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_tx", tx_line[0], 1'b1);
    check("async_rst_ready", ready_line[0], 1'b1);
    check("async_rst_busy", busy_line[0], 1'b0);
    check("async_rst_done", done_line[0], 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // 8N1, 0xA5.
    push_exp(0, "0101001011", 1'b0, 1'b0);
    send(0, 9'h0A5, 1'b0);
    wait_done(0);

    // Even and odd parity on 0x07, and even parity on 0x00.
    push_exp(1, "01110000011", 1'b0, 1'b0);
    send(1, 9'h007, 1'b0);
    wait_done(1);
    push_exp(2, "01110000001", 1'b0, 1'b0);
    send(2, 9'h007, 1'b0);
    wait_done(2);
    push_exp(1, "00000000001", 1'b0, 1'b0);
    send(1, 9'h000, 1'b0);
    wait_done(1);

    // 7 data bits, 2 stop bits: 0x41 and 0x7F.
    push_exp(3, "0100000111", 1'b0, 1'b0);
    send(3, 9'h041, 1'b0);
    wait_done(3);
    push_exp(3, "0111111111", 1'b0, 1'b0);
    send(3, 9'h07F, 1'b0);
    wait_done(3);

    // Back-to-back with valid held high: 0x55 then 0xAA.
    push_exp(0, "0101010101", 1'b0, 1'b0);
    push_exp(0, "0010101011", 1'b1, 1'b0);
    send(0, 9'h055, 1'b0);
    data_v[0]  = 9'h0AA;
    valid_v[0] = 1'b1;
    dones = 0;
    drops = 0;
    acc2  = 1'b0;
    for (int i = 0; i < 600 && dones < 2; i++) begin
      @(negedge clk);
      if (acc2) valid_v[0] = 1'b0;
      if (done_line[0]) dones++;
      if (dones < 2 && !busy_line[0]) drops++;
      if (valid_v[0] && ready_line[0]) acc2 = 1'b1;
    end
    valid_v[0] = 1'b0;
    check("b2b_second_accept", acc2, 1'b1);
    check("b2b_done_pulses", dones, 2);
    check("b2b_busy_drops", drops, 0);
    @(negedge clk);

    // Accept in the same cycle as a tick: the start bit waits for the next tick.
    push_exp(0, "0001111001", 1'b0, 1'b1);
    send(0, 9'h03C, 1'b1);
    wait_done(0);

    // Drain and confirm every expected frame was seen.
    for (int i = 0; i < 2000; i++) begin
      if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() == 0) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) check("queue_empty", exp_q[k].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
